// File: rtl/vram_access_port.sv
// vram_access_port: CPU byte port into the 32-bit video RAM.
// Keeps a 17-bit byte address with programmable auto-step and a prefetched
// read byte, and turns CPU strobes into word bus cycles for the arbiter/RAM.
//
// Bus handshake: bus_req is held high with every bus_* output stable until a
// cycle in which bus_ack is also high; the RAM samples the bus on that clock
// edge and the request is complete. For reads, bus_rddata is valid during the
// cycle after the ack. There is no back-pressure on the read data.
module vram_access_port #(
   parameter int INCR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [16:0]          cpu_addr,
   input  logic                 cpu_addr_wr,
   input  logic [INCR_BITS-1:0] cpu_incr_sel,
   input  logic                 cpu_decr,
   input  logic                 cpu_data_rd,
   input  logic                 cpu_data_wr,
   input  logic [7:0]           cpu_wrdata,
   output logic [7:0]           cpu_rddata,
   output logic [16:0]          cpu_addr_q,
   output logic                 busy,
   output logic                 overrun,
   output logic                 bus_req,
   input  logic                 bus_ack,
   output logic [14:0]          bus_addr,
   output logic [31:0]          bus_wrdata,
   output logic [3:0]           bus_wrbytesel,
   output logic                 bus_write,
   input  logic [31:0]          bus_rddata,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      RD_CAP  = 3'd4
   } state_t;

   state_t      state_q, next_state;
   logic [16:0] addr_q;
   logic [16:0] step;
   logic [16:0] addr_step;
   logic [14:0] wr_addr_q;
   logic [1:0]  lane_q;
   logic [7:0]  rddata_q;
   logic [31:0] wrdata_q;
   logic [3:0]  bytesel_q;
   logic        overrun_q;
   logic        do_load, do_wr, do_rd;
   logic        any_strobe;

   assign any_strobe    = cpu_addr_wr | cpu_data_wr | cpu_data_rd;
   // RD_CAP presents the freshly captured byte and is already idle for strobes.
   assign busy          = (state_q == WR_REQ) || (state_q == RD_REQ) || (state_q == RD_WAIT);
   assign cpu_addr_q    = addr_q;
   assign cpu_rddata    = rddata_q;
   assign overrun       = overrun_q;
   assign bus_wrdata    = wrdata_q;
   assign bus_wrbytesel = bytesel_q;
   assign bus_addr      = (state_q == WR_REQ) ? wr_addr_q : addr_q[16:2];
   assign dbg_state     = state_q;

   // Step size and the stepped address (wraps modulo 2^17 in both directions).
   always_comb begin
      step = '0;
      if (cpu_incr_sel != '0)
         step = 17'(1) << (cpu_incr_sel - INCR_BITS'(1));
      addr_step = cpu_decr ? (addr_q - step) : (addr_q + step);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= next_state;
   end

   // Next-state, strobe acceptance with priority addr_wr > data_wr > data_rd, bus request.
   always_comb begin
      next_state = state_q;
      bus_req    = 1'b0;
      bus_write  = 1'b0;
      do_load    = 1'b0;
      do_wr      = 1'b0;
      do_rd      = 1'b0;
      case (state_q)
         IDLE, RD_CAP: begin
            next_state = IDLE;
            if (cpu_addr_wr) begin
               do_load    = 1'b1;
               next_state = RD_REQ;
            end else if (cpu_data_wr) begin
               do_wr      = 1'b1;
               next_state = WR_REQ;
            end else if (cpu_data_rd) begin
               do_rd      = 1'b1;
               next_state = RD_REQ;
            end
         end
         WR_REQ: begin
            bus_req   = 1'b1;
            bus_write = 1'b1;
            if (bus_ack)
               next_state = RD_REQ;
         end
         RD_REQ: begin
            bus_req = 1'b1;
            if (bus_ack)
               next_state = RD_WAIT;
         end
         RD_WAIT: next_state = RD_CAP;
         default: next_state = IDLE;
      endcase
   end

   // Address, write latches, prefetch lane, read capture and sticky overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         wr_addr_q <= '0;
         lane_q    <= '0;
         rddata_q  <= '0;
         wrdata_q  <= '0;
         bytesel_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (busy && any_strobe)
            overrun_q <= 1'b1;

         if (do_load) begin
            addr_q <= cpu_addr;
            lane_q <= cpu_addr[1:0];
         end else if (do_wr) begin
            wr_addr_q <= addr_q[16:2];
            wrdata_q  <= {4{cpu_wrdata}};
            bytesel_q <= 4'b0001 << addr_q[1:0];
            addr_q    <= addr_step;
         end else if (do_rd) begin
            addr_q <= addr_step;
            lane_q <= addr_step[1:0];
         end

         // Write accepted: switch to the re-prefetch of the (already stepped) address.
         if (state_q == WR_REQ && bus_ack) begin
            bytesel_q <= '0;
            lane_q    <= addr_q[1:0];
         end

         // RAM data is valid during RD_WAIT; it becomes visible as RD_CAP starts.
         if (state_q == RD_WAIT) begin
            case (lane_q)
               2'd0:    rddata_q <= bus_rddata[7:0];
               2'd1:    rddata_q <= bus_rddata[15:8];
               2'd2:    rddata_q <= bus_rddata[23:16];
               default: rddata_q <= bus_rddata[31:24];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vram_access_port.sv
// tb_vram_access_port: directed test of the VRAM byte port against a small RAM model.
module tb_vram_access_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] cpu_addr;
   logic        cpu_addr_wr;
   logic [3:0]  cpu_incr_sel;
   logic        cpu_decr;
   logic        cpu_data_rd;
   logic        cpu_data_wr;
   logic [7:0]  cpu_wrdata;
   logic [7:0]  cpu_rddata;
   logic [16:0] cpu_addr_q;
   logic        busy;
   logic        overrun;
   logic        bus_req;
   logic        bus_ack;
   logic [14:0] bus_addr;
   logic [31:0] bus_wrdata;
   logic [3:0]  bus_wrbytesel;
   logic        bus_write;
   logic [31:0] bus_rddata;
   logic [2:0]  dbg_state;

   logic [31:0] ram [0:32767];
   logic        ram_clear;
   int          wr_count = 0;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          w0;

   vram_access_port #(.INCR_BITS(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_addr      (cpu_addr),
      .cpu_addr_wr   (cpu_addr_wr),
      .cpu_incr_sel  (cpu_incr_sel),
      .cpu_decr      (cpu_decr),
      .cpu_data_rd   (cpu_data_rd),
      .cpu_data_wr   (cpu_data_wr),
      .cpu_wrdata    (cpu_wrdata),
      .cpu_rddata    (cpu_rddata),
      .cpu_addr_q    (cpu_addr_q),
      .busy          (busy),
      .overrun       (overrun),
      .bus_req       (bus_req),
      .bus_ack       (bus_ack),
      .bus_addr      (bus_addr),
      .bus_wrdata    (bus_wrdata),
      .bus_wrbytesel (bus_wrbytesel),
      .bus_write     (bus_write),
      .bus_rddata    (bus_rddata),
      .dbg_state     (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // RAM model: samples the bus on an acked request, registered read data.
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 32768; i++) ram[i] <= 32'h0;
         ram[15'h1000] <= 32'h12345678;
      end else if (bus_req && bus_ack) begin
         if (bus_write) begin
            for (int b = 0; b < 4; b++)
               if (bus_wrbytesel[b]) ram[bus_addr][b*8 +: 8] <= bus_wrdata[b*8 +: 8];
            wr_count <= wr_count + 1;
         end else begin
            bus_rddata <= ram[bus_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (busy && n < max_cycles) begin
         tick();
         n++;
      end
      check(tag, busy, 1'b0);
   endtask

   task automatic load_addr(input logic [16:0] a);
      cpu_addr    = a;
      cpu_addr_wr = 1'b1;
      tick();
      cpu_addr_wr = 1'b0;
      wait_idle("load_idle", 20);
   endtask

   task automatic data_rd();
      cpu_data_rd = 1'b1;
      tick();
      cpu_data_rd = 1'b0;
      wait_idle("rd_idle", 20);
   endtask

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ram_clear = 1'b1; bus_ack = 1'b1; bus_rddata = 32'h0;
      cpu_addr = '0; cpu_addr_wr = 1'b0; cpu_incr_sel = 4'd1; cpu_decr = 1'b0;
      cpu_data_rd = 1'b0; cpu_data_wr = 1'b0; cpu_wrdata = '0;
      tick(); tick();

      // Reset state.
      check("rst_rddata",  cpu_rddata, 8'h00);
      check("rst_addr",    cpu_addr_q, 17'h0);
      check("rst_busy",    busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_req",     bus_req, 1'b0);
      check("rst_baddr",   bus_addr, 15'h0);
      check("rst_wrdata",  bus_wrdata, 32'h0);
      check("rst_bytesel", bus_wrbytesel, 4'h0);
      check("rst_write",   bus_write, 1'b0);
      check("rst_state",   dbg_state, 3'd0);
      rst = 1'b0; ram_clear = 1'b0;
      tick();
      check("no_prefetch_on_rst", bus_req, 1'b0);

      // Load 0x04001: cycle-accurate prefetch latency.
      cpu_addr = 17'h04001; cpu_addr_wr = 1'b1; cpu_incr_sel = 4'd1;
      tick();
      cpu_addr_wr = 1'b0;
      check("c1_req",   bus_req, 1'b1);
      check("c1_baddr", bus_addr, 15'h1000);
      check("c1_write", bus_write, 1'b0);
      check("c1_busy",  busy, 1'b1);
      tick();
      check("c2_req",   bus_req, 1'b0);
      check("c2_busy",  busy, 1'b1);
      tick();
      check("c3_rddata", cpu_rddata, 8'h56);
      check("c3_busy",   busy, 1'b0);

      // Read strobe: step to 0x04002, prefetch lane 2.
      data_rd();
      check("rd_addr",   cpu_addr_q, 17'h04002);
      check("rd_rddata", cpu_rddata, 8'h34);

      // Write 0xAB at 0x04002, then re-prefetch 0x04003.
      w0 = wr_count;
      cpu_wrdata = 8'hAB; cpu_data_wr = 1'b1;
      tick();
      cpu_data_wr = 1'b0;
      check("w1_bytesel", bus_wrbytesel, 4'b0100);
      check("w1_wrdata",  bus_wrdata, 32'hABABABAB);
      check("w1_write",   bus_write, 1'b1);
      check("w1_baddr",   bus_addr, 15'h1000);
      check("w1_addr",    cpu_addr_q, 17'h04003);
      tick();
      check("w2_write",   bus_write, 1'b0);
      check("w2_bytesel", bus_wrbytesel, 4'b0000);
      check("w2_req",     bus_req, 1'b1);
      tick();
      check("w3_busy",    busy, 1'b1);
      tick();
      check("w4_busy",    busy, 1'b0);
      check("w4_rddata",  cpu_rddata, 8'h12);
      check("w_ram",      ram[15'h1000], 32'h12AB5678);
      check("w_count",    wr_count - w0, 1);

      // Wrap upward, then decrement by 0x4000 with wrap downward.
      load_addr(17'h1FFFF);
      data_rd();
      check("wrap_up", cpu_addr_q, 17'h00000);
      cpu_decr = 1'b1; cpu_incr_sel = 4'd15;
      data_rd();
      check("wrap_down", cpu_addr_q, 17'h1C000);
      cpu_decr = 1'b0; cpu_incr_sel = 4'd1;

      // Arbiter stalls a write for 5 cycles; a read strobe mid-stall overruns.
      load_addr(17'h00010);
      w0 = wr_count;
      bus_ack = 1'b0; cpu_wrdata = 8'hCD; cpu_data_wr = 1'b1;
      tick();
      cpu_data_wr = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check("st_req",     bus_req, 1'b1);
         check("st_write",   bus_write, 1'b1);
         check("st_baddr",   bus_addr, 15'h0004);
         check("st_wrdata",  bus_wrdata, 32'hCDCDCDCD);
         check("st_bytesel", bus_wrbytesel, 4'b0001);
         check("st_busy",    busy, 1'b1);
         cpu_data_rd = (c == 2);
         tick();
      end
      cpu_data_rd = 1'b0;
      check("st_overrun", overrun, 1'b1);
      check("st_addr",    cpu_addr_q, 17'h00011);
      check("st_nowrite", wr_count - w0, 0);
      bus_ack = 1'b1;
      wait_idle("st_idle", 20);
      check("st_once",    wr_count - w0, 1);
      check("st_ram",     ram[15'h0004], 32'h000000CD);
      check("st_rddata",  cpu_rddata, 8'h00);

      // Reset while a write waits for its grant: the write is dropped.
      w0 = wr_count;
      bus_ack = 1'b0; cpu_wrdata = 8'hEE; cpu_data_wr = 1'b1;
      tick();
      cpu_data_wr = 1'b0;
      check("mr_req", bus_req, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0; bus_ack = 1'b1;
      check("mr_req0",     bus_req, 1'b0);
      check("mr_write0",   bus_write, 1'b0);
      check("mr_busy0",    busy, 1'b0);
      check("mr_overrun0", overrun, 1'b0);
      check("mr_addr0",    cpu_addr_q, 17'h0);
      check("mr_baddr0",   bus_addr, 15'h0);
      check("mr_wrdata0",  bus_wrdata, 32'h0);
      check("mr_bytesel0", bus_wrbytesel, 4'h0);
      check("mr_rddata0",  cpu_rddata, 8'h00);
      tick(); tick();
      check("mr_nowrite",  wr_count - w0, 0);
      check("mr_ram",      ram[15'h0004], 32'h000000CD);

      // Simultaneous load and read strobe: load wins, no step, no overrun.
      cpu_addr = 17'h00123; cpu_addr_wr = 1'b1; cpu_data_rd = 1'b1;
      tick();
      cpu_addr_wr = 1'b0; cpu_data_rd = 1'b0;
      check("sim_addr1", cpu_addr_q, 17'h00123);
      wait_idle("sim_idle", 20);
      check("sim_addr2",   cpu_addr_q, 17'h00123);
      check("sim_overrun", overrun, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
